// File: rtl/sha256_core_arbiter.sv
// Two-port arbiter/sequencer sharing one SHA-256 core. A requester owns the core
// from its first block through its last; blocks are issued one at a time and the
// final digest is returned to the owner on the shared digest bus.
module sha256_core_arbiter #(
    parameter int unsigned BLK_W = 512,
    parameter int unsigned DIG_W = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_first,
    input  logic [1:0]       req_last,
    input  logic [BLK_W-1:0] req_msg0,
    input  logic [BLK_W-1:0] req_msg1,
    output logic [1:0]       req_ready,
    output logic [1:0]       dig_valid,
    output logic [DIG_W-1:0] dig_out,
    output logic [1:0]       err,
    output logic             core_valid,
    output logic             core_first,
    output logic             core_last,
    output logic [BLK_W-1:0] core_msg,
    input  logic             core_ready,
    input  logic [DIG_W-1:0] core_digest
);

    // The core is locked to owner_q whenever the FSM is outside StIdle.
    typedef enum logic [2:0] {StIdle, StIssue, StWait, StNext, StDone} state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             last_q, last_d;
    logic             blank_q, blank_d;
    logic [1:0]       req_ready_q, req_ready_d;
    logic [1:0]       err_q, err_d;
    logic [1:0]       dig_valid_q, dig_valid_d;
    logic [DIG_W-1:0] dig_out_q, dig_out_d;
    logic             core_valid_q, core_valid_d;
    logic             core_first_q, core_first_d;
    logic             core_last_q, core_last_d;
    logic [BLK_W-1:0] core_msg_q, core_msg_d;

    logic [1:0]       live;
    logic [1:0]       cand;
    logic             issue;

    // Next-state, grant and registered-output computation.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        last_d       = last_q;
        blank_d      = 1'b0;
        req_ready_d  = '0;
        err_d        = '0;
        dig_valid_d  = '0;
        dig_out_d    = dig_out_q;
        core_valid_d = 1'b0;
        core_first_d = 1'b0;
        core_last_d  = 1'b0;
        core_msg_d   = '0;
        issue        = 1'b0;
        // A block acknowledged last cycle is still on the bus; do not act on it twice.
        live         = req_valid & ~req_ready_q;
        cand         = live & req_first;

        unique case (state_q)
            StIdle: begin
                if (cand != 2'b00) begin
                    // On a tie the requester that did not own the core last wins.
                    owner_d = (cand == 2'b11) ? ~rr_ptr_q : cand[1];
                    issue   = 1'b1;
                end else begin
                    // Continuation block with no message in progress: drop it.
                    req_ready_d = live;
                    err_d       = live;
                end
            end
            StIssue: begin
                state_d = StWait;
                blank_d = 1'b1;
            end
            StWait: begin
                // First WAIT cycle is blanked: the core may not have dropped ready yet.
                if (!blank_q && core_ready) begin
                    if (last_q) begin
                        state_d              = StDone;
                        dig_valid_d[owner_q] = 1'b1;
                        dig_out_d            = core_digest;
                    end else begin
                        state_d = StNext;
                    end
                end
            end
            StNext: begin
                if (req_valid[owner_q]) begin
                    issue          = 1'b1;
                    // A new first block mid-message restarts the message.
                    err_d[owner_q] = req_first[owner_q];
                end
            end
            StDone: begin
                rr_ptr_d = owner_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (issue) begin
            state_d              = StIssue;
            core_valid_d         = 1'b1;
            req_ready_d[owner_d] = 1'b1;
            core_first_d         = req_first[owner_d];
            core_last_d          = req_last[owner_d];
            last_d               = req_last[owner_d];
            core_msg_d           = owner_d ? req_msg1 : req_msg0;
        end
    end

    // State and output registers; async reset clears every output at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            rr_ptr_q     <= 1'b1;
            last_q       <= 1'b0;
            blank_q      <= 1'b0;
            req_ready_q  <= '0;
            err_q        <= '0;
            dig_valid_q  <= '0;
            dig_out_q    <= '0;
            core_valid_q <= 1'b0;
            core_first_q <= 1'b0;
            core_last_q  <= 1'b0;
            core_msg_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            last_q       <= last_d;
            blank_q      <= blank_d;
            req_ready_q  <= req_ready_d;
            err_q        <= err_d;
            dig_valid_q  <= dig_valid_d;
            dig_out_q    <= dig_out_d;
            core_valid_q <= core_valid_d;
            core_first_q <= core_first_d;
            core_last_q  <= core_last_d;
            core_msg_q   <= core_msg_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign err        = err_q;
    assign dig_valid  = dig_valid_q;
    assign dig_out    = dig_out_q;
    assign core_valid = core_valid_q;
    assign core_first = core_first_q;
    assign core_last  = core_last_q;
    assign core_msg   = core_msg_q;

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Bench for sha256_core_arbiter with a behavioural SHA-256 core model.
module tb_sha256_core_arbiter;

    localparam int LAT = 4;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [447:0] S56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    localparam logic [511:0] BLK_A1  = {S56, 8'h80, 56'h0};
    localparam logic [511:0] BLK_A2  = 512'h1c0;
    localparam logic [511:0] BLK_ABC = {24'h616263, 8'h80, 416'h0, 64'd24};
    localparam logic [511:0] BLK_EMP = {8'h80, 504'h0};
    localparam logic [255:0] DIG_A   =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMP =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = '0, req_first = '0, req_last = '0;
    logic [511:0] req_msg0 = '0, req_msg1 = '0;
    logic [1:0]   req_ready, dig_valid, err;
    logic [255:0] dig_out;
    logic         core_valid, core_first, core_last, core_ready;
    logic [511:0] core_msg;
    logic [255:0] core_digest;

    always #5 clk = ~clk;

    sha256_core_arbiter #(.BLK_W(512), .DIG_W(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_first(req_first), .req_last(req_last),
        .req_msg0(req_msg0), .req_msg1(req_msg1),
        .req_ready(req_ready), .dig_valid(dig_valid), .dig_out(dig_out), .err(err),
        .core_valid(core_valid), .core_first(core_first), .core_last(core_last),
        .core_msg(core_msg), .core_ready(core_ready), .core_digest(core_digest)
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] b);
        logic [31:0] w [64];
        logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = w[t-16] + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
                 + w[t-7] + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
        {a, bb, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + bb, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Core model: ready stays high one cycle after accepting (exercises blanking),
    // then low for LAT cycles; the digest only updates when ready returns.
    logic         m_busy, m_rdy;
    int           m_cnt;
    logic [255:0] m_h, m_pend;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_rdy <= 1'b1; m_cnt <= 0; m_h <= '0; m_pend <= '0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0; m_rdy <= 1'b1; m_h <= m_pend;
            end else begin
                m_cnt <= m_cnt - 1; m_rdy <= 1'b0;
            end
        end else if (core_valid && m_rdy) begin
            m_busy <= 1'b1; m_cnt <= LAT;
            m_pend <= sha_compress(core_first ? IV : m_h, core_msg);
        end
    end
    assign core_ready  = m_rdy;
    assign core_digest = m_h;

    typedef struct packed { logic port; logic [255:0] dig; } exp_t;
    exp_t sb_q [$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int n_cv = 0, n_dig = 0, n_err_rdy = 0;
    int n_rdy [2] = '{0, 0};
    int n_err [2] = '{0, 0};
    int last_issue = 0, prev_issue = 0, dig0_cyc = -1, rdy1_cyc = -1;
    logic last_cfirst = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: event counters and the digest scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (core_valid) begin
                n_cv++; last_cfirst = core_first; prev_issue = last_issue; last_issue = cyc;
            end
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) n_rdy[i]++;
                if (err[i]) n_err[i]++;
                if (err[i] && req_ready[i]) n_err_rdy++;
            end
            if (req_ready[1] && rdy1_cyc < 0) rdy1_cyc = cyc;
            if (dig_valid != 2'b00) begin
                exp_t e;
                n_dig++;
                if (dig_valid[0]) dig0_cyc = cyc;
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_digest", 512'(dig_valid), 512'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("dig_port", 512'(dig_valid), 512'(e.port ? 2'b10 : 2'b01));
                    chk("dig_value", 512'(dig_out), 512'(e.dig));
                end
            end
        end
    end

    task automatic push_exp(input logic p, input logic [255:0] d);
        exp_t e;
        e.port = p; e.dig = d;
        sb_q.push_back(e);
    endtask

    task automatic send_blk(input logic p, input logic f, input logic l, input logic [511:0] m);
        bit ok;
        @(posedge clk); #1;
        req_valid[p] = 1'b1; req_first[p] = f; req_last[p] = l;
        if (p) req_msg1 = m; else req_msg0 = m;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[p]) ok = 1'b1;
        end
        if (!ok) chk($sformatf("req%0d_ready_timeout", p), 512'(ok), 512'(1));
        @(posedge clk); #1;
        req_valid[p] = 1'b0; req_first[p] = 1'b0; req_last[p] = 1'b0;
    endtask

    task automatic send_msg(input logic p, input int nblk, input logic [511:0] b0,
                            input logic [511:0] b1);
        if (nblk == 1) begin
            send_blk(p, 1'b1, 1'b1, b0);
        end else begin
            send_blk(p, 1'b1, 1'b0, b0);
            send_blk(p, 1'b0, 1'b1, b1);
        end
    endtask

    task automatic wait_dig(input int target, input string name);
        for (int k = 0; k < 600 && n_dig < target; k++) @(negedge clk);
        chk(name, 512'(n_dig >= target), 512'(1));
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctrl"}, 512'({req_ready, dig_valid, err, core_valid, core_first, core_last}),
            512'(0));
        chk({name, "_core_msg"}, core_msg, 512'(0));
        chk({name, "_dig_out"}, 512'(dig_out), 512'(0));
    endtask

    typedef struct {
        logic         port;
        int           nblk;
        logic [511:0] b0;
        logic [511:0] b1;
        logic [255:0] exp;
    } vec_t;
    vec_t tbl [4];

    initial begin
        int cv0, d0, e0, r0, er0;
        tbl[0] = '{1'b0, 2, BLK_A1, BLK_A2, DIG_A};
        tbl[1] = '{1'b1, 1, BLK_ABC, '0, DIG_ABC};
        tbl[2] = '{1'b0, 1, BLK_EMP, '0, DIG_EMP};
        tbl[3] = '{1'b1, 2, BLK_A1, BLK_A2, DIG_A};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Table: one message per record, digest and core issue count checked.
        for (int i = 0; i < 4; i++) begin
            cv0 = n_cv; d0 = n_dig;
            push_exp(tbl[i].port, tbl[i].exp);
            send_msg(tbl[i].port, tbl[i].nblk, tbl[i].b0, tbl[i].b1);
            wait_dig(d0 + 1, $sformatf("vec%0d_digest", i));
            chk($sformatf("vec%0d_core_valids", i), 512'(n_cv - cv0), 512'(tbl[i].nblk));
        end

        // Tie straight after reset: requester 0 wins, then requester 1.
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        d0 = n_dig; rdy1_cyc = -1;
        push_exp(1'b0, DIG_EMP);
        push_exp(1'b1, DIG_ABC);
        fork
            send_msg(1'b0, 1, BLK_EMP, '0);
            send_msg(1'b1, 1, BLK_ABC, '0);
        join
        wait_dig(d0 + 2, "tie_digests");
        chk("tie_req1_after_dig0", 512'(rdy1_cyc > dig0_cyc), 512'(1));

        // No interleave: requester 1 waits while requester 0 sits between blocks.
        d0 = n_dig; rdy1_cyc = -1;
        push_exp(1'b0, DIG_A);
        push_exp(1'b1, DIG_ABC);
        fork
            begin
                send_blk(1'b0, 1'b1, 1'b0, BLK_A1);
                repeat (10) @(posedge clk);
                send_blk(1'b0, 1'b0, 1'b1, BLK_A2);
            end
            begin
                repeat (4) @(posedge clk);
                send_blk(1'b1, 1'b1, 1'b1, BLK_ABC);
            end
        join
        wait_dig(d0 + 2, "nointerleave_digests");
        chk("nointerleave_rdy1_after_dig0", 512'(rdy1_cyc > dig0_cyc), 512'(1));

        // Reset while waiting on the core: outputs clear at once, no digest appears.
        d0 = n_dig;
        send_blk(1'b0, 1'b1, 1'b0, BLK_A1);
        #2 rst_n = 1'b0;
        #1 chk_zero("midreset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        chk("midreset_no_digest", 512'(n_dig - d0), 512'(0));
        push_exp(1'b0, DIG_A);
        send_msg(1'b0, 2, BLK_A1, BLK_A2);
        wait_dig(d0 + 1, "midreset_resend_digest");

        // Continuation block with nothing in progress is dropped with an error.
        r0 = n_rdy[1]; e0 = n_err[1]; er0 = n_err_rdy; cv0 = n_cv;
        send_blk(1'b1, 1'b0, 1'b1, BLK_ABC);
        repeat (4) @(posedge clk);
        chk("drop_ready", 512'(n_rdy[1] - r0), 512'(1));
        chk("drop_err", 512'(n_err[1] - e0), 512'(1));
        chk("drop_err_with_ready", 512'(n_err_rdy - er0), 512'(1));
        chk("drop_no_core_valid", 512'(n_cv - cv0), 512'(0));

        // Owner restarts its message in the middle.
        d0 = n_dig; e0 = n_err[0]; cv0 = n_cv;
        push_exp(1'b0, DIG_ABC);
        send_blk(1'b0, 1'b1, 1'b0, BLK_A1);
        send_blk(1'b0, 1'b1, 1'b1, BLK_ABC);
        wait_dig(d0 + 1, "restart_digest");
        chk("restart_err", 512'(n_err[0] - e0), 512'(1));
        chk("restart_core_valids", 512'(n_cv - cv0), 512'(2));
        chk("restart_core_first", 512'(last_cfirst), 512'(1));

        // Back-to-back single-block messages, then a tie that requester 1 must win.
        d0 = n_dig; cv0 = n_cv;
        push_exp(1'b0, DIG_EMP);
        push_exp(1'b0, DIG_EMP);
        send_msg(1'b0, 1, BLK_EMP, '0);
        send_msg(1'b0, 1, BLK_EMP, '0);
        wait_dig(d0 + 2, "b2b_digests");
        chk("b2b_core_valids", 512'(n_cv - cv0), 512'(2));
        chk("b2b_issue_spacing", 512'((last_issue - prev_issue) >= LAT + 3), 512'(1));
        d0 = n_dig;
        push_exp(1'b1, DIG_ABC);
        push_exp(1'b0, DIG_EMP);
        fork
            send_msg(1'b0, 1, BLK_EMP, '0);
            send_msg(1'b1, 1, BLK_ABC, '0);
        join
        wait_dig(d0 + 2, "rr_tie_digests");

        chk("sb_empty", 512'(sb_q.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
